puf_eval_ctrl: RTL

Sequencer between the host-side command handler and the PUF mapping stage. It latches a challenge and PDL configuration, then runs a programmable number of PUF evaluations. Each evaluation is a reset, trigger, settle and sample cycle. The block accumulates the XOR response bits and returns the last raw response, a ones count and a majority-vote bit to the host. The mapping stage has no usable completion signal, so all PUF timing is owned here by a fixed settle counter.

---
 rtl/puf_eval_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences repeated PUF evaluations (reset, trigger, settle,
// sample) and reports the last raw response, a ones count and a majority bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; PUF held in reset
// CLEAR  | one-cycle PUF reset before each evaluation
// FIRE   | trigger held while the settle counter runs
// SAMPLE | trigger still high; response captured, eval counter bumped
// DONE   | results copied to the outputs, result_valid pulsed next cycle
//
// All outputs are registered from the current state, so they trail the
// state register by one cycle (e.g. result_valid is high the cycle after DONE).
module puf_eval_ctrl #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 64,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int SETTLE_CYCLES    = 16,
    parameter int REPEAT_WIDTH     = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [CHALLENGE_WIDTH-1:0]  challenge_in_i,
    input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in_i,
    input  logic [REPEAT_WIDTH-1:0]     repeat_count_i,
    output logic                        busy_o,
    output logic                        result_valid_o,
    output logic [REPEAT_WIDTH-1:0]     ones_count_o,
    output logic                        majority_o,
    output logic [RESPONSE_WIDTH-1:0]   last_raw_response_o,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge_o,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config_o,
    output logic                        puf_trigger_o,
    output logic                        puf_reset_o,
    input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response_i,
    input  logic                        puf_xor_response_i
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CHALLENGE_WIDTH-1:0]  chal_q, chal_d;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_q, pdl_d;
    logic [REPEAT_WIDTH-1:0]     n_q, n_d;
    logic [REPEAT_WIDTH-1:0]     eval_q, eval_d;
    logic [REPEAT_WIDTH-1:0]     acc_q, acc_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic [RESPONSE_WIDTH-1:0]   raw_q, raw_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;
    logic [REPEAT_WIDTH-1:0]     ones_q, ones_d;
    logic                        maj_q, maj_d;
    logic [RESPONSE_WIDTH-1:0]   last_raw_q, last_raw_d;
    logic                        trig_q, trig_d;
    logic                        preset_q, preset_d;
    logic [REPEAT_WIDTH-1:0]     eval_inc;

    assign eval_inc = eval_q + REPEAT_WIDTH'(1);

    // Next-state, datapath updates and registered-output values.
    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        pdl_d      = pdl_q;
        n_d        = n_q;
        eval_d     = eval_q;
        acc_d      = acc_q;
        settle_d   = settle_q;
        raw_d      = raw_q;
        ones_d     = ones_q;
        maj_d      = maj_q;
        last_raw_d = last_raw_q;

        busy_d     = (state_q != S_IDLE);
        valid_d    = (state_q == S_DONE);
        trig_d     = (state_q == S_FIRE) || (state_q == S_SAMPLE);
        preset_d   = !trig_d;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    chal_d  = challenge_in_i;
                    pdl_d   = pdl_config_in_i;
                    n_d     = (repeat_count_i == '0) ? REPEAT_WIDTH'(1) : repeat_count_i;
                    eval_d  = '0;
                    acc_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                settle_d = '0;
                state_d  = S_FIRE;
            end
            S_FIRE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                raw_d  = puf_raw_response_i;
                acc_d  = acc_q + {{(REPEAT_WIDTH-1){1'b0}}, puf_xor_response_i};
                eval_d = eval_inc;
                state_d = (eval_inc == n_q) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                ones_d     = acc_q;
                maj_d      = ({acc_q, 1'b0} > {1'b0, n_q});
                last_raw_d = raw_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any evaluation.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            chal_q     <= '0;
            pdl_q      <= '0;
            n_q        <= '0;
            eval_q     <= '0;
            acc_q      <= '0;
            settle_q   <= '0;
            raw_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ones_q     <= '0;
            maj_q      <= 1'b0;
            last_raw_q <= '0;
            trig_q     <= 1'b0;
            preset_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            pdl_q      <= pdl_d;
            n_q        <= n_d;
            eval_q     <= eval_d;
            acc_q      <= acc_d;
            settle_q   <= settle_d;
            raw_q      <= raw_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ones_q     <= ones_d;
            maj_q      <= maj_d;
            last_raw_q <= last_raw_d;
            trig_q     <= trig_d;
            preset_q   <= preset_d;
        end
    end

    assign busy_o              = busy_q;
    assign result_valid_o      = valid_q;
    assign ones_count_o        = ones_q;
    assign majority_o          = maj_q;
    assign last_raw_response_o = last_raw_q;
    assign puf_challenge_o     = chal_q;
    assign puf_pdl_config_o    = pdl_q;
    assign puf_trigger_o       = trig_q;
    assign puf_reset_o         = preset_q;

endmodule
